mfm_read_seq: RTL and testbench

MFM_READ_SEQ -- requirements
Module: mfm_read_seq

---
 rtl/mfm_read_seq.sv | 163 ++++++++++++++++
 tb/tb_mfm_read_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mfm_read_seq.sv
// MFM floppy read sequencer: hunts for A1 sync, validates the address/data mark,
// streams the field to the host and checks the trailing CRC-16-CCITT.
module mfm_read_seq #(
  parameter int          INDEX_LIMIT  = 5,
  parameter logic [47:0] SYNC_PATTERN = 48'h448944894489
) (
  input  logic        iCLK,
  input  logic        iRESETn,
  input  logic        iCMD_GO,
  input  logic        iCMD_DATA,
  input  logic [1:0]  iSECLEN,
  input  logic        iABORT,
  input  logic        iINDEX,
  input  logic [47:0] i3WORDS,
  input  logic [7:0]  iBYTE,
  input  logic        iBYTE_STB,
  output logic        oSTART,
  output logic        oSYNC,
  output logic [7:0]  oDATA,
  output logic        oDRQ,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oCRC_ERR,
  output logic        oRNF,
  output logic        oDELMARK
);

  localparam int IW = $clog2(INDEX_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HUNT, S_MARK, S_FIELD, S_CRC1, S_CRC2, S_FIN
  } state_t;

  state_t      r_state, w_state_next;
  logic        r_index_d;
  logic [IW-1:0] r_index_cnt;
  logic        r_cmd_data;
  logic [1:0]  r_seclen;
  logic [9:0]  r_byte_cnt;
  logic [15:0] r_crc;
  logic        r_sync, r_drq, r_crc_err, r_rnf, r_delmark;
  logic [7:0]  r_data;

  logic        w_sync_hit, w_index_edge, w_index_full, w_mark_ok, w_abort;
  logic [9:0]  w_last_idx;
  logic [15:0] w_crc_next;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c;
    for (int i = 7; i >= 0; i--) begin
      if (x[15] ^ d[i]) x = {x[14:0], 1'b0} ^ 16'h1021;
      else              x = {x[14:0], 1'b0};
    end
    return x;
  endfunction

  assign w_sync_hit   = (i3WORDS == SYNC_PATTERN);
  assign w_index_edge = iINDEX & ~r_index_d;
  assign w_index_full = (r_index_cnt == IW'(INDEX_LIMIT - 1));
  assign w_mark_ok    = r_cmd_data ? ((iBYTE == 8'hFB) || (iBYTE == 8'hF8)) : (iBYTE == 8'hFE);
  assign w_last_idx   = r_cmd_data ? 10'((11'd128 << r_seclen) - 11'd1) : 10'd3;
  assign w_crc_next   = crc_byte(r_crc, iBYTE);
  assign w_abort      = iABORT && (r_state != S_IDLE);

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Sync match is tested before the index edge so a coincident edge is never counted.
  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (iCMD_GO) w_state_next = S_HUNT;
        S_HUNT: begin
          if (w_sync_hit)                        w_state_next = S_MARK;
          else if (w_index_edge && w_index_full) w_state_next = S_FIN;
        end
        S_MARK:  if (iBYTE_STB) w_state_next = w_mark_ok ? S_FIELD : S_HUNT;
        S_FIELD: if (iBYTE_STB && (r_byte_cnt == w_last_idx)) w_state_next = S_CRC1;
        S_CRC1:  if (iBYTE_STB) w_state_next = S_CRC2;
        S_CRC2:  if (iBYTE_STB) w_state_next = S_FIN;
        S_FIN:   w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_index_d   <= 1'b0;
      r_index_cnt <= '0;
      r_cmd_data  <= 1'b0;
      r_seclen    <= 2'd0;
      r_byte_cnt  <= 10'd0;
      r_crc       <= 16'hFFFF;
      r_sync      <= 1'b0;
      r_drq       <= 1'b0;
      r_data      <= 8'h00;
      r_crc_err   <= 1'b0;
      r_rnf       <= 1'b0;
      r_delmark   <= 1'b0;
    end else begin
      r_index_d <= iINDEX;
      r_sync    <= 1'b0;
      r_drq     <= 1'b0;
      if (!w_abort) begin
        case (r_state)
          S_IDLE: if (iCMD_GO) begin
            r_crc_err   <= 1'b0;
            r_rnf       <= 1'b0;
            r_delmark   <= 1'b0;
            r_cmd_data  <= iCMD_DATA;
            r_seclen    <= iSECLEN;
            r_index_cnt <= '0;
          end
          S_HUNT: begin
            if (w_sync_hit) begin
              r_sync <= 1'b1;
              r_crc  <= 16'hCDB4;
            end else if (w_index_edge) begin
              r_index_cnt <= r_index_cnt + 1'b1;
              if (w_index_full) r_rnf <= 1'b1;
            end
          end
          S_MARK: if (iBYTE_STB && w_mark_ok) begin
            r_crc      <= w_crc_next;
            r_byte_cnt <= 10'd0;
            r_delmark  <= (iBYTE == 8'hF8);
          end
          S_FIELD: if (iBYTE_STB) begin
            r_data     <= iBYTE;
            r_drq      <= 1'b1;
            r_crc      <= w_crc_next;
            r_byte_cnt <= r_byte_cnt + 10'd1;
          end
          S_CRC1: if (iBYTE_STB) r_crc <= w_crc_next;
          S_CRC2: if (iBYTE_STB) begin
            r_crc     <= w_crc_next;
            r_crc_err <= (w_crc_next != 16'h0000);
          end
          default: ;
        endcase
      end
    end
  end

  assign oBUSY    = (r_state != S_IDLE);
  assign oSTART   = (r_state == S_HUNT) || (r_state == S_MARK) || (r_state == S_FIELD) ||
                    (r_state == S_CRC1) || (r_state == S_CRC2);
  assign oDONE    = (r_state == S_FIN) && !iABORT;
  assign oSYNC    = r_sync;
  assign oDRQ     = r_drq;
  assign oDATA    = r_data;
  assign oCRC_ERR = r_crc_err;
  assign oRNF     = r_rnf;
  assign oDELMARK = r_delmark;

endmodule

// File: tb/tb_mfm_read_seq.sv
// Directed-plus-random bench for mfm_read_seq; expected field bytes and CRC status
// come from a message-level CRC model over the whole A1 A1 A1 + mark + field stream.
module tb_mfm_read_seq;

  localparam logic [47:0] SYNC = 48'h448944894489;

  logic        iCLK = 1'b0, iRESETn = 1'b0;
  logic        iCMD_GO = 1'b0, iCMD_DATA = 1'b0, iABORT = 1'b0, iINDEX = 1'b0, iBYTE_STB = 1'b0;
  logic [1:0]  iSECLEN = 2'd0;
  logic [47:0] i3WORDS = 48'h0;
  logic [7:0]  iBYTE = 8'h00;
  logic        oSTART, oSYNC, oDRQ, oBUSY, oDONE, oCRC_ERR, oRNF, oDELMARK;
  logic [7:0]  oDATA;

  int checks = 0;
  int fails  = 0;
  int done_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  mfm_read_seq dut (
    .iCLK(iCLK), .iRESETn(iRESETn), .iCMD_GO(iCMD_GO), .iCMD_DATA(iCMD_DATA),
    .iSECLEN(iSECLEN), .iABORT(iABORT), .iINDEX(iINDEX), .i3WORDS(i3WORDS),
    .iBYTE(iBYTE), .iBYTE_STB(iBYTE_STB), .oSTART(oSTART), .oSYNC(oSYNC),
    .oDATA(oDATA), .oDRQ(oDRQ), .oBUSY(oBUSY), .oDONE(oDONE), .oCRC_ERR(oCRC_ERR),
    .oRNF(oRNF), .oDELMARK(oDELMARK)
  );

  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) begin
    if (oDRQ) got_q.push_back(oDATA);
    if (oDONE) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC-CCITT over the whole on-disk byte stream, starting from FFFF before the sync bytes.
  function automatic logic [15:0] ref_crc(input logic [7:0] msg[$]);
    logic [15:0] r;
    logic [7:0]  b;
    logic        fb;
    r = 16'hFFFF;
    for (int k = 0; k < 3 + msg.size(); k++) begin
      b = (k < 3) ? 8'hA1 : msg[k-3];
      for (int i = 7; i >= 0; i--) begin
        fb = r[15] ^ b[i];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h1021;
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic go(input bit cmd, input logic [1:0] sl);
    iCMD_GO = 1'b1; iCMD_DATA = cmd; iSECLEN = sl;
    step();
    iCMD_GO = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    iBYTE = b; iBYTE_STB = 1'b1;
    step();
    iBYTE_STB = 1'b0;
    repeat ($urandom_range(0, 2)) step();
  endtask

  // Sync word presented together with a junk byte strobe, which must be discarded.
  task automatic sync_pulse(input string tag);
    repeat ($urandom_range(0, 2)) step();
    i3WORDS = SYNC; iBYTE = 8'($urandom); iBYTE_STB = 1'b1;
    step();
    i3WORDS = {16'h0, 32'($urandom)}; iBYTE_STB = 1'b0;
    check($sformatf("%s.sync", tag), 32'(oSYNC), 32'd1);
  endtask

  task automatic index_pulse();
    iINDEX = 1'b1; step();
    iINDEX = 1'b0; step();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (oBUSY && n < 40) begin
      step();
      n++;
    end
    check($sformatf("%s.idle", tag), 32'(oBUSY), 32'd0);
  endtask

  task automatic fill(input int n);
    exp_q.delete();
    repeat (n) exp_q.push_back(8'($urandom));
  endtask

  task automatic run_read(input bit cmd, input logic [1:0] sl, input logic [7:0] mark,
                          input bit corrupt, input bit bad_first, input string tag);
    logic [7:0]  msg[$];
    logic [15:0] c;
    int d0, mism;
    got_q.delete();
    d0 = done_cnt;
    go(cmd, sl);
    check($sformatf("%s.busy", tag), {oBUSY, oSTART}, 2'b11);
    if (bad_first) begin
      sync_pulse($sformatf("%s.bad", tag));
      send_byte(cmd ? 8'hFE : 8'hFB);
      step();
      check($sformatf("%s.badmark", tag), {oBUSY, oSTART, 30'(got_q.size())}, 32'hC000_0000);
    end
    sync_pulse(tag);
    msg.delete();
    msg.push_back(mark);
    foreach (exp_q[k]) msg.push_back(exp_q[k]);
    c = ref_crc(msg);
    foreach (msg[k]) send_byte(msg[k]);
    send_byte(c[15:8]);
    send_byte(corrupt ? (c[7:0] ^ 8'($urandom_range(1, 255))) : c[7:0]);
    wait_idle(tag);
    mism = 0;
    foreach (exp_q[k]) if (k >= got_q.size() || got_q[k] !== exp_q[k]) mism++;
    check($sformatf("%s.count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    check($sformatf("%s.data", tag), 32'(mism), 32'd0);
    check($sformatf("%s.flags", tag), {oCRC_ERR, oDELMARK, oRNF},
          {corrupt, (mark == 8'hF8), 1'b0});
    check($sformatf("%s.done", tag), 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    logic [1:0] sl;
    bit cmd;

    // Reset state
    step(); step();
    check("reset.outs", {oSTART, oSYNC, oDRQ, oBUSY, oDONE, oCRC_ERR, oRNF, oDELMARK, oDATA}, 32'h0);
    #2 iRESETn = 1'b1;
    step();

    // ID read with the reference ID bytes
    exp_q.delete();
    exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h03); exp_q.push_back(8'h01);
    run_read(1'b0, 2'd0, 8'hFE, 1'b0, 1'b0, "id");

    // 256-byte data field, deleted mark, corrupted CRC
    fill(256);
    run_read(1'b1, 2'd1, 8'hF8, 1'b1, 1'b0, "data256");

    // Wrong mark on a data command, then a normal FB field
    fill(128);
    run_read(1'b1, 2'd0, 8'hFB, 1'b0, 1'b1, "wrongmark");

    // Randomised reads
    for (int it = 0; it < 5; it++) begin
      cmd = 1'($urandom);
      sl  = 2'($urandom_range(0, 3));
      fill(cmd ? (128 << sl) : 4);
      run_read(cmd, sl, cmd ? (($urandom & 1) ? 8'hF8 : 8'hFB) : 8'hFE,
               1'($urandom), 1'($urandom), $sformatf("rand%0d", it));
    end

    // Record not found after five index pulses; a sixth changes nothing
    d0 = done_cnt;
    go(1'b0, 2'd0);
    repeat (4) index_pulse();
    check("rnf.pre", {oBUSY, oRNF}, 2'b10);
    iINDEX = 1'b1; step();
    check("rnf.fifth", {oRNF, oDONE}, 2'b11);
    iINDEX = 1'b0; step();
    check("rnf.idle", 32'(oBUSY), 32'd0);
    index_pulse();
    check("rnf.sixth", {oBUSY, oRNF, 30'(done_cnt - d0)}, {2'b01, 30'd1});

    // Sync beats a coincident index edge; a rejected mark keeps the count
    go(1'b0, 2'd0);
    repeat (4) index_pulse();
    i3WORDS = SYNC; iINDEX = 1'b1;
    step();
    i3WORDS = 48'h0; iINDEX = 1'b0;
    check("race.sync", 32'(oSYNC), 32'd1);
    send_byte(8'h00);
    step();
    check("race.hunt", {oBUSY, oSTART, oRNF}, 3'b110);
    index_pulse();
    check("race.rnf", 32'(oRNF), 32'd1);
    wait_idle("race");

    // Abort after byte 10 of a data field
    got_q.delete();
    d0 = done_cnt;
    go(1'b1, 2'd2);
    sync_pulse("abort");
    send_byte(8'hFB);
    repeat (10) send_byte(8'($urandom));
    iABORT = 1'b1; step(); iABORT = 1'b0;
    check("abort.outs", {oBUSY, oSTART}, 2'b00);
    step(); step();
    check("abort.nodone", 32'(done_cnt - d0), 32'd0);
    check("abort.count", 32'(got_q.size()), 32'd10);
    fill(4);
    run_read(1'b0, 2'd0, 8'hFE, 1'b0, 1'b0, "after_abort");

    // GO and ABORT together in IDLE: GO wins
    iABORT = 1'b1;
    go(1'b0, 2'd0);
    iABORT = 1'b0;
    check("goabort.busy", 32'(oBUSY), 32'd1);
    iABORT = 1'b1; step(); iABORT = 1'b0;

    // Asynchronous reset mid-field, then GO on the first edge after release
    go(1'b1, 2'd0);
    sync_pulse("rst");
    send_byte(8'hF8);
    repeat (5) send_byte(8'hA5);
    #2 iRESETn = 1'b0;
    #1 check("rst.async", {oSTART, oSYNC, oDRQ, oBUSY, oDONE, oCRC_ERR, oRNF, oDELMARK, oDATA}, 32'h0);
    iCMD_GO = 1'b1; iCMD_DATA = 1'b0;
    #3 iRESETn = 1'b1;
    step();
    iCMD_GO = 1'b0;
    check("rst.go", {oBUSY, oSTART}, 2'b11);
    iABORT = 1'b1; step(); iABORT = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
